control_unit: RTL

Microcoded-style Moore FSM controller for the 8-bit accumulator CPU. It consumes `opcode` and `ACisZero` from the datapath and drives every datapath enable and mux select, sequencing fetch, address-byte reads, memory access and execute for the 16-opcode instruction set. It sits directly above the datapath in the CPU top level.

---
 rtl/control_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Moore control FSM for the 8-bit accumulator CPU: 2-6 cycles per instruction, outputs decoded from state+opcode.
// No backpressure (memory is single-cycle); optional HALT state for opcode FF under CU_HALT_EN.
module control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         opcode,
  input  logic               ACisZero,
  output logic               writeEnableAC,
  output logic               writeEnableR,
  output logic               writeEnableMem,
  output logic               PCEnable,
  output logic               instructionRegisterEnable,
  output logic               dataRegisterEnable,
  output logic               MSBaddressEnable,
  output logic               LSBaddressEnable,
  output logic               zeroEnable,
  output logic               muxSelectPC,
  output logic               muxSelectAddress,
  output logic               muxSelectALUtoAC,
  output logic               muxSelectMEM_or_R_toAC,
  output logic [STATE_W-1:0] state,
  output logic               halted
);

  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_JUMP = 8'h05;
  localparam logic [7:0] OP_JMPZ = 8'h06;
  localparam logic [7:0] OP_JPNZ = 8'h07;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_JUMP,
    S_MEM_RD,
    S_MEM_LOAD,
    S_MEM_WR,
    S_EXEC
`ifdef CU_HALT_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic we_ac;
    logic we_r;
    logic we_mem;
    logic pc_en;
    logic ir_en;
    logic dr_en;
    logic msb_en;
    logic lsb_en;
    logic z_en;
    logic sel_pc;
    logic sel_addr;
    logic sel_alu_ac;
    logic sel_mem_r;
    logic halt;
  } ctl_t;

  state_t cur;
  state_t nxt;
  ctl_t   ctl;
  logic   is_gamma;
  logic   is_alu;
  logic   is_exec;

  assign is_gamma = (opcode == OP_LDAC) || (opcode == OP_STAC) || (opcode == OP_JUMP) ||
                    (opcode == OP_JMPZ) || (opcode == OP_JPNZ);
  assign is_alu   = (opcode[7:3] == 5'b00001);
  assign is_exec  = is_alu || (opcode == OP_MVAC) || (opcode == OP_MOVR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    ctl = '0;
    nxt = cur;
    case (cur)
      S_FETCH: begin
        ctl.ir_en = 1'b1;
        ctl.pc_en = 1'b1;
        nxt       = S_DECODE;
      end
      S_DECODE: begin
        if (is_gamma)     nxt = S_ADDR_HI;
        else if (is_exec) nxt = S_EXEC;
`ifdef CU_HALT_EN
        else if (opcode == 8'hFF) nxt = S_HALT;
`endif
        else              nxt = S_FETCH;
      end
      S_ADDR_HI: begin
        ctl.msb_en = 1'b1;
        ctl.pc_en  = 1'b1;
        nxt        = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        ctl.lsb_en = 1'b1;
        ctl.pc_en  = 1'b1;
        // Branch condition is taken from the Z flag as it stands in this cycle
        case (opcode)
          OP_LDAC: nxt = S_MEM_RD;
          OP_STAC: nxt = S_MEM_WR;
          OP_JUMP: nxt = S_JUMP;
          OP_JMPZ: nxt = ACisZero ? S_JUMP : S_FETCH;
          OP_JPNZ: nxt = ACisZero ? S_FETCH : S_JUMP;
          default: nxt = S_FETCH;
        endcase
      end
      S_JUMP: begin
        ctl.sel_pc = 1'b1;
        ctl.pc_en  = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_RD: begin
        ctl.sel_addr = 1'b1;
        ctl.dr_en    = 1'b1;
        nxt          = S_MEM_LOAD;
      end
      S_MEM_LOAD: begin
        ctl.sel_alu_ac = 1'b1;
        ctl.sel_mem_r  = 1'b1;
        ctl.we_ac      = 1'b1;
        nxt            = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.sel_addr = 1'b1;
        ctl.we_mem   = 1'b1;
        nxt          = S_FETCH;
      end
      S_EXEC: begin
        if (opcode == OP_MVAC) begin
          ctl.we_r = 1'b1;
        end else if (opcode == OP_MOVR) begin
          ctl.sel_alu_ac = 1'b1;
          ctl.we_ac      = 1'b1;
        end else if (is_alu) begin
          ctl.we_ac = 1'b1;
          ctl.z_en  = 1'b1;
        end
        nxt = S_FETCH;
      end
`ifdef CU_HALT_EN
      S_HALT: begin
        ctl.halt = 1'b1;
        nxt      = S_HALT;
      end
`endif
      default: nxt = S_FETCH;
    endcase
  end

  // Every output is held low combinationally while reset is asserted
  assign writeEnableAC             = ctl.we_ac      & reset;
  assign writeEnableR              = ctl.we_r       & reset;
  assign writeEnableMem            = ctl.we_mem     & reset;
  assign PCEnable                  = ctl.pc_en      & reset;
  assign instructionRegisterEnable = ctl.ir_en      & reset;
  assign dataRegisterEnable        = ctl.dr_en      & reset;
  assign MSBaddressEnable          = ctl.msb_en     & reset;
  assign LSBaddressEnable          = ctl.lsb_en     & reset;
  assign zeroEnable                = ctl.z_en       & reset;
  assign muxSelectPC               = ctl.sel_pc     & reset;
  assign muxSelectAddress          = ctl.sel_addr   & reset;
  assign muxSelectALUtoAC          = ctl.sel_alu_ac & reset;
  assign muxSelectMEM_or_R_toAC    = ctl.sel_mem_r  & reset;
  assign halted                    = ctl.halt       & reset;
  assign state                     = cur;

endmodule
